// File: rtl/register_bank_mp.sv
// DEPTH x DATA_WIDTH register file: two combinational read ports, one write port,
// optional write-to-read bypass and hardwired-zero entry 0, plus a sequential clear sweep.

module register_bank_mp_rdport #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  input  logic [DATA_WIDTH-1:0] entry_i,
  input  logic                  busy_i,
  input  logic                  wr_fire_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);
  // Zero-register test precedes bypass so r0 never forwards write data.
  always_comb begin
    rdata_o = entry_i;
    if (busy_i)
      rdata_o = '0;
    else if ((ZERO_REG != 0) && (raddr_i == '0))
      rdata_o = '0;
    else if ((BYPASS != 0) && wr_fire_i && (waddr_i == raddr_i))
      rdata_o = wdata_i;
  end
endmodule

module register_bank_mp #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] Read_register_1,
  input  logic [ADDR_WIDTH-1:0] Read_register_2,
  output logic [DATA_WIDTH-1:0] Read_data_1,
  output logic [DATA_WIDTH-1:0] Read_data_2,
  input  logic [ADDR_WIDTH-1:0] Write_register,
  input  logic [DATA_WIDTH-1:0] Write_data,
  input  logic                  write,
  input  logic                  clear,
  output logic                  busy,
  output logic                  write_dropped
);
  localparam int DEPTH     = 2**ADDR_WIDTH;
  localparam int NUM_PORTS = 2;

  typedef enum logic {CLEAR, IDLE} state_e;

  state_e                              state_q, state_d;
  logic [ADDR_WIDTH-1:0]               ptr_q, ptr_d;
  logic                                drop_q, drop_d;
  logic [DEPTH-1:0][DATA_WIDTH-1:0]    mem_q;
  logic                                wr_fire, wr_en;
  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] raddr;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      drop_q  <= drop_d;
    end
  end

  // clear beats write in IDLE, and any write during a sweep is lost.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    drop_d  = write && ((state_q == CLEAR) || clear);
    case (state_q)
      CLEAR: begin
        ptr_d = ptr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
        if (&ptr_q) state_d = IDLE;
      end
      IDLE: begin
        if (clear) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end
      end
      default: begin
        state_d = CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

  assign wr_fire = (state_q == IDLE) && !clear && write;
  assign wr_en   = wr_fire && !((ZERO_REG != 0) && (Write_register == '0));

  // Storage is not reset; the sweep zeroes it one entry per edge instead.
  always_ff @(posedge clk) begin
    if (state_q == CLEAR)
      mem_q[ptr_q] <= '0;
    else if (wr_en)
      mem_q[Write_register] <= Write_data;
  end

  assign busy          = (state_q == CLEAR);
  assign write_dropped = drop_q;

  assign raddr = {Read_register_2, Read_register_1};

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_rd
    register_bank_mp_rdport #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH),
      .ZERO_REG  (ZERO_REG),
      .BYPASS    (BYPASS)
    ) u_rd (
      .raddr_i  (raddr[g]),
      .entry_i  (mem_q[raddr[g]]),
      .busy_i   (busy),
      .wr_fire_i(wr_fire),
      .waddr_i  (Write_register),
      .wdata_i  (Write_data),
      .rdata_o  (rdata[g])
    );
  end

  assign Read_data_1 = rdata[0];
  assign Read_data_2 = rdata[1];
endmodule

// File: tb/tb_register_bank_mp.sv
// Directed bench for register_bank_mp: default-parameter instance plus a BYPASS=0 twin
// driven by the same stimulus.

module tb_register_bank_mp;
  logic        clk;
  logic        rst_n;
  logic [4:0]  rr1, rr2, wr;
  logic [63:0] wd;
  logic        write, clear;
  logic [63:0] rd1, rd2, nb_rd1, nb_rd2;
  logic        busy, drop, nb_busy, nb_drop;

  int checks = 0;
  int errors = 0;

  register_bank_mp dut (
    .clk(clk), .rst_n(rst_n),
    .Read_register_1(rr1), .Read_register_2(rr2),
    .Read_data_1(rd1), .Read_data_2(rd2),
    .Write_register(wr), .Write_data(wd),
    .write(write), .clear(clear),
    .busy(busy), .write_dropped(drop)
  );

  register_bank_mp #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n),
    .Read_register_1(rr1), .Read_register_2(rr2),
    .Read_data_1(nb_rd1), .Read_data_2(nb_rd2),
    .Write_register(wr), .Write_data(wd),
    .write(write), .clear(clear),
    .busy(nb_busy), .write_dropped(nb_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 32; i++) begin
      rr1 = 5'(i);
      rr2 = 5'(31 - i);
      #1;
      chk({tag, "_p1"}, rd1, 64'h0);
      chk({tag, "_p2"}, rd2, 64'h0);
    end
  endtask

  initial begin
    int n;
    int bad;
    rst_n = 1'b0; rr1 = '0; rr2 = '0; wr = '0; wd = '0; write = 1'b0; clear = 1'b0;

    // Reset state
    #23;
    chk("rst_busy", busy, 1);
    chk("rst_drop", drop, 0);
    chk("rst_rd1", rd1, 0);

    // Post-reset sweep: busy for exactly 32 edges after release
    #4 rst_n = 1'b1;
    n = 0; bad = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      n++;
      if (drop !== 1'b0) bad++;
      if (!busy) break;
    end
    chk("rst_sweep_edges", n, 32);
    chk("rst_sweep_drop", bad, 0);
    chk("nb_busy_done", nb_busy, 0);
    check_all_zero("post_rst");

    // Write r5, read on both ports the next cycle
    wr = 5'd5; wd = 64'hDEAD_BEEF_0123_4567; write = 1'b1; rr1 = 5'd7; rr2 = 5'd7;
    step();
    write = 1'b0; rr1 = 5'd5; rr2 = 5'd5;
    #1;
    chk("r5_p1", rd1, 64'hDEAD_BEEF_0123_4567);
    chk("r5_p2", rd2, 64'hDEAD_BEEF_0123_4567);
    chk("nb_r5_p1", nb_rd1, 64'hDEAD_BEEF_0123_4567);

    // Zero register ignores writes and never bypasses
    wr = 5'd0; wd = '1; write = 1'b1; rr1 = 5'd0; rr2 = 5'd0;
    #1;
    chk("r0_bypass", rd1, 0);
    step();
    write = 1'b0;
    #1;
    chk("r0_p1", rd1, 0);
    chk("r0_p2", rd2, 0);
    chk("r0_drop", drop, 0);

    // Same-cycle bypass vs old value with BYPASS=0
    wr = 5'd7; wd = 64'hA5; write = 1'b1; rr1 = 5'd7; rr2 = 5'd5;
    #1;
    chk("byp_rd1", rd1, 64'hA5);
    chk("byp_rd2_other", rd2, 64'hDEAD_BEEF_0123_4567);
    chk("nobyp_old", nb_rd1, 0);
    step();
    write = 1'b0;
    #1;
    chk("nobyp_after", nb_rd1, 64'hA5);
    chk("byp_after", rd1, 64'hA5);

    // Fill r1..r31, then clear with a colliding write
    for (int i = 1; i < 32; i++) begin
      wr = 5'(i); wd = 64'h1000 + 64'(i); write = 1'b1;
      step();
    end
    write = 1'b0; rr1 = 5'd3; rr2 = 5'd31;
    #1;
    chk("fill_r3", rd1, 64'h1003);
    chk("fill_r31", rd2, 64'h101F);
    clear = 1'b1; write = 1'b1; wr = 5'd3; wd = 64'h999;
    step();
    clear = 1'b0; write = 1'b0;
    chk("clr_drop", drop, 1);
    chk("clr_busy", busy, 1);
    chk("clr_read_busy", rd1, 0);
    n = 1;
    step();
    n++;
    chk("clr_drop_pulse", drop, 0);
    for (int k = 0; k < 40 && busy; k++) begin
      step();
      n++;
    end
    chk("clr_sweep_edges", n, 33);
    check_all_zero("post_clr");

    // Writes during sweep are dropped; clear during sweep is ignored
    wr = 5'd4; wd = 64'h44; write = 1'b1;
    step();
    write = 1'b0; rr1 = 5'd4;
    #1;
    chk("r4_pre", rd1, 64'h44);
    clear = 1'b1;
    step();
    clear = 1'b0;
    for (int k = 0; k < 10; k++) step();
    clear = 1'b1; write = 1'b1; wr = 5'd4; wd = 64'h77;
    step();
    clear = 1'b0;
    chk("mid_drop1", drop, 1);
    step();
    chk("mid_drop2", drop, 1);
    step();
    chk("mid_drop3", drop, 1);
    write = 1'b0;
    n = 0;
    step();
    n++;
    chk("mid_drop_end", drop, 0);
    for (int k = 0; k < 40 && busy; k++) begin
      step();
      n++;
    end
    chk("mid_remaining_edges", n, 19);
    rr1 = 5'd4;
    #1;
    chk("mid_r4_zero", rd1, 0);

    // Reset in the middle of a sweep restarts a full 32-edge sweep
    wr = 5'd9; wd = 64'h99; write = 1'b1;
    step();
    write = 1'b0; rr1 = 5'd9;
    #1;
    chk("r9_pre", rd1, 64'h99);
    clear = 1'b1;
    step();
    clear = 1'b0;
    for (int k = 0; k < 20; k++) step();
    rst_n = 1'b0;
    #2;
    chk("midrst_busy", busy, 1);
    chk("midrst_rd", rd1, 0);
    #3 rst_n = 1'b1;
    n = 0; bad = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      n++;
      if (rd1 !== 64'h0) bad++;
      if (!busy) break;
    end
    chk("midrst_edges", n, 32);
    chk("midrst_reads", bad, 0);
    check_all_zero("post_midrst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
